// File: rtl/mtimer_pkg.sv
// rtl/mtimer_pkg.sv - register map constants and byte-merge helper for the machine timer
package mtimer_pkg;

    localparam logic [4:0] MTIMER_CTRL        = 5'h00;
    localparam logic [4:0] MTIMER_MTIME_LO    = 5'h04;
    localparam logic [4:0] MTIMER_MTIME_HI    = 5'h08;
    localparam logic [4:0] MTIMER_MTIMECMP_LO = 5'h0C;
    localparam logic [4:0] MTIMER_MTIMECMP_HI = 5'h10;
    localparam logic [4:0] MTIMER_PRESCALE    = 5'h14;
    localparam logic [4:0] MTIMER_FREQ        = 5'h18;

    localparam int MTIMER_CTRL_ENABLE_BIT  = 0;
    localparam int MTIMER_CTRL_PENDING_BIT = 1;

    localparam logic [63:0] MTIMER_MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam int          MTIMER_PRESCALE_W     = 16;

    // Byte-wise merge of a bus write into an existing 32-bit register
    function automatic logic [31:0] mtimer_merge_bytes(input logic [31:0] old_value,
                                                       input logic [31:0] new_value,
                                                       input logic [3:0]  strobe);
        logic [31:0] merged;
        merged = old_value;
        for (int b = 0; b < 4; b++) begin
            if (strobe[b]) begin
                merged[8*b +: 8] = new_value[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/mtimer_prescaler.sv
// rtl/mtimer_prescaler.sv - prescale counter producing one mtime tick every PRESCALE+1 enabled cycles (built under MTIMER_PRESCALER_EN)
module mtimer_prescaler
    import mtimer_pkg::*;
(
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         i_count_en,
    input  logic                         i_clear,
    input  logic [MTIMER_PRESCALE_W-1:0] i_prescale,
    output logic                         o_tick
);

    logic [MTIMER_PRESCALE_W-1:0] r_count;
    logic                         w_wrap;

    assign w_wrap = (r_count == i_prescale);
    assign o_tick = i_count_en && w_wrap;

    // Count enabled cycles, wrap on reaching PRESCALE; a PRESCALE rewrite restarts from 0
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_count_en) begin
            r_count <= w_wrap ? '0 : r_count + 1'b1;
        end
    end

endmodule

// File: rtl/mtimer_controller.sv
// rtl/mtimer_controller.sv - RISC-V machine timer (mtime/mtimecmp/irq) on the RVX bus; optional prescaler via MTIMER_PRESCALER_EN
module mtimer_controller
    import mtimer_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY = 12000000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        halt,
    input  logic [4:0]  address,
    input  logic        read_request,
    output logic [31:0] read_data,
    output logic        read_response,
    input  logic        write_request,
    input  logic [31:0] write_data,
    input  logic [3:0]  write_strobe,
    output logic        write_response,
    output logic        irq
);

    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic [31:0] r_shadow;
    logic        r_enable;
    logic        r_irq;
    logic [31:0] r_read_data;
    logic        r_read_response;
    logic        r_write_response;

    logic [2:0]  w_word;
    logic        w_wr_ctrl;
    logic        w_wr_mtime_lo;
    logic        w_wr_mtime_hi;
    logic        w_wr_cmp_lo;
    logic        w_wr_cmp_hi;
    logic        w_rd_mtime_lo;
    logic        w_count_en;
    logic        w_tick;
    logic [31:0] w_prescale_rd;
    logic [31:0] w_ctrl_rd;
    logic [31:0] w_read_mux;
    logic        w_unused_addr;

    assign w_word        = address[4:2];
    assign w_unused_addr = ^address[1:0];

    assign w_wr_ctrl     = write_request && (w_word == MTIMER_CTRL[4:2]);
    assign w_wr_mtime_lo = write_request && (w_word == MTIMER_MTIME_LO[4:2]);
    assign w_wr_mtime_hi = write_request && (w_word == MTIMER_MTIME_HI[4:2]);
    assign w_wr_cmp_lo   = write_request && (w_word == MTIMER_MTIMECMP_LO[4:2]);
    assign w_wr_cmp_hi   = write_request && (w_word == MTIMER_MTIMECMP_HI[4:2]);
    assign w_rd_mtime_lo = read_request  && (w_word == MTIMER_MTIME_LO[4:2]);

    assign w_count_en = r_enable && !halt;

`ifdef MTIMER_PRESCALER_EN
    logic [MTIMER_PRESCALE_W-1:0] r_prescale;
    logic                         w_wr_prescale;

    assign w_wr_prescale = write_request && (w_word == MTIMER_PRESCALE[4:2]);
    assign w_prescale_rd = {16'd0, r_prescale};

    // PRESCALE register, byte-strobed on its low two bytes
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_prescale <= '0;
        end else if (w_wr_prescale) begin
            r_prescale <= {write_strobe[1] ? write_data[15:8] : r_prescale[15:8],
                           write_strobe[0] ? write_data[7:0]  : r_prescale[7:0]};
        end
    end

    mtimer_prescaler u_prescaler (
        .clock      (clock),
        .reset_n    (reset_n),
        .i_count_en (w_count_en),
        .i_clear    (w_wr_prescale),
        .i_prescale (r_prescale),
        .o_tick     (w_tick)
    );
`else
    assign w_prescale_rd = '0;
    assign w_tick        = w_count_en;
`endif

    // mtime: a software write to either half wins over that cycle's tick, with no carry between halves
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_mtime <= '0;
        end else if (w_wr_mtime_lo) begin
            r_mtime[31:0] <= mtimer_merge_bytes(r_mtime[31:0], write_data, write_strobe);
        end else if (w_wr_mtime_hi) begin
            r_mtime[63:32] <= mtimer_merge_bytes(r_mtime[63:32], write_data, write_strobe);
        end else if (w_tick) begin
            r_mtime <= r_mtime + 64'd1;
        end
    end

    // mtimecmp and CTRL.enable registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_mtimecmp <= MTIMER_MTIMECMP_RESET;
            r_enable   <= 1'b1;
        end else begin
            if (w_wr_cmp_lo) begin
                r_mtimecmp[31:0] <= mtimer_merge_bytes(r_mtimecmp[31:0], write_data, write_strobe);
            end
            if (w_wr_cmp_hi) begin
                r_mtimecmp[63:32] <= mtimer_merge_bytes(r_mtimecmp[63:32], write_data, write_strobe);
            end
            if (w_wr_ctrl && write_strobe[0]) begin
                r_enable <= write_data[MTIMER_CTRL_ENABLE_BIT];
            end
        end
    end

    // Timer interrupt level, re-evaluated from the registered values every cycle
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= (r_mtime >= r_mtimecmp);
        end
    end

    // CTRL read image
    always_comb begin
        w_ctrl_rd                          = '0;
        w_ctrl_rd[MTIMER_CTRL_ENABLE_BIT]  = r_enable;
        w_ctrl_rd[MTIMER_CTRL_PENDING_BIT] = r_irq;
    end

    // Read mux over pre-write register values
    always_comb begin
        w_read_mux = '0;
        case (w_word)
            MTIMER_CTRL[4:2]:        w_read_mux = w_ctrl_rd;
            MTIMER_MTIME_LO[4:2]:    w_read_mux = r_mtime[31:0];
            MTIMER_MTIME_HI[4:2]:    w_read_mux = r_shadow;
            MTIMER_MTIMECMP_LO[4:2]: w_read_mux = r_mtimecmp[31:0];
            MTIMER_MTIMECMP_HI[4:2]: w_read_mux = r_mtimecmp[63:32];
            MTIMER_PRESCALE[4:2]:    w_read_mux = w_prescale_rd;
            MTIMER_FREQ[4:2]:        w_read_mux = 32'(CLOCK_FREQUENCY);
            default:                 w_read_mux = '0;
        endcase
    end

    // Bus responses one cycle after the strobe; LO read snapshots the high half for a coherent HI read
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_read_data      <= '0;
            r_read_response  <= 1'b0;
            r_write_response <= 1'b0;
            r_shadow         <= '0;
        end else begin
            r_read_data      <= read_request ? w_read_mux : '0;
            r_read_response  <= read_request;
            r_write_response <= write_request;
            if (w_rd_mtime_lo) begin
                r_shadow <= r_mtime[63:32];
            end
        end
    end

    assign read_data      = r_read_data;
    assign read_response  = r_read_response;
    assign write_response = r_write_response;
    assign irq            = r_irq;

endmodule

// File: tb/tb_mtimer_controller.sv
// tb/tb_mtimer_controller.sv - self-checking bench for mtimer_controller (vector table + read scoreboard)
module tb_mtimer_controller;

    localparam logic [4:0] A_CTRL   = 5'h00;
    localparam logic [4:0] A_MLO    = 5'h04;
    localparam logic [4:0] A_MHI    = 5'h08;
    localparam logic [4:0] A_CLO    = 5'h0C;
    localparam logic [4:0] A_CHI    = 5'h10;
    localparam logic [4:0] A_PS     = 5'h14;
    localparam logic [4:0] A_FREQ   = 5'h18;
    localparam logic [4:0] A_NONE   = 5'h1C;
    localparam logic [31:0] FREQ_HZ = 32'd12000000;
    localparam logic [3:0] ALL      = 4'b1111;

    logic        clock;
    logic        reset_n;
    logic        halt;
    logic [4:0]  address;
    logic        read_request;
    logic [31:0] read_data;
    logic        read_response;
    logic        write_request;
    logic [31:0] write_data;
    logic [3:0]  write_strobe;
    logic        write_response;
    logic        irq;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } sb_t;

    typedef struct {
        bit          wr;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    sb_t  sb[$];
    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;
    logic m_rd, m_wr, m_rst;
    logic [31:0] exp_ps;

    mtimer_controller #(.CLOCK_FREQUENCY(12000000)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .halt           (halt),
        .address        (address),
        .read_request   (read_request),
        .read_data      (read_data),
        .read_response  (read_response),
        .write_request  (write_request),
        .write_data     (write_data),
        .write_strobe   (write_strobe),
        .write_response (write_response),
        .irq            (irq)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_read(input logic [4:0] a, input logic [31:0] e);
        sb.push_back('{a, e});
        address      = a;
        read_request = 1'b1;
        @(negedge clock);
        read_request = 1'b0;
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        address       = a;
        write_data    = d;
        write_strobe  = s;
        write_request = 1'b1;
        @(negedge clock);
        write_request = 1'b0;
    endtask

    task automatic bus_rw(input logic [4:0] a, input logic [31:0] d, input logic [31:0] e);
        sb.push_back('{a, e});
        address       = a;
        write_data    = d;
        write_strobe  = ALL;
        write_request = 1'b1;
        read_request  = 1'b1;
        @(negedge clock);
        write_request = 1'b0;
        read_request  = 1'b0;
    endtask

    // Response monitor: checks pulses and pops the scoreboard for every read strobe
    always @(posedge clock) begin
        sb_t e;
        m_rd  = read_request;
        m_wr  = write_request;
        m_rst = reset_n;
        #1;
        if ((m_rd && m_rst) || read_response)
            chk("read_response", read_response, m_rd && m_rst);
        if ((m_wr && m_rst) || write_response)
            chk("write_response", write_response, m_wr && m_rst);
        if (m_rd) begin
            if (sb.size() == 0) begin
                chk("scoreboard_underflow", 1, 0);
            end else begin
                e = sb.pop_front();
                if (m_rst && read_response)
                    chk($sformatf("read_data@%0h", e.addr), read_data, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n       = 1'b0;
        halt          = 1'b0;
        address       = '0;
        read_request  = 1'b0;
        write_request = 1'b0;
        write_data    = '0;
        write_strobe  = '0;

        // Reset state
        repeat (3) @(negedge clock);
        chk("reset_irq", irq, 0);
        chk("reset_read_response", read_response, 0);
        chk("reset_write_response", write_response, 0);
        chk("reset_read_data", read_data, 0);
        reset_n = 1'b1;

        // Free running from reset: ten ticks then read
        repeat (10) @(negedge clock);
        bus_read(A_MLO, 32'd10);
        bus_read(A_FREQ, FREQ_HZ);
        bus_read(A_CTRL, 32'h1);
        chk("irq_idle", irq, 0);

        // Compare match at 20
        bus_write(A_CTRL, 32'h0, ALL);
        bus_write(A_MHI, 32'h0, ALL);
        bus_write(A_MLO, 32'h0, ALL);
        bus_write(A_CHI, 32'h0, ALL);
        bus_write(A_CLO, 32'd20, ALL);
        bus_write(A_CTRL, 32'h1, ALL);
        repeat (20) @(negedge clock);
        chk("irq_before_match", irq, 0);
        @(negedge clock);
        chk("irq_after_match", irq, 1);
        bus_read(A_CTRL, 32'h3);
        bus_read(A_MLO, 32'd22);
        bus_write(A_CLO, 32'hFFFF_FFFF, ALL);
        chk("irq_hold_after_cmp_raise", irq, 1);
        @(negedge clock);
        chk("irq_fall_after_cmp_raise", irq, 0);
        bus_read(A_CTRL, 32'h1);

        // 32-bit carry and coherent LO/HI read
        bus_write(A_CHI, 32'hFFFF_FFFF, ALL);
        bus_write(A_MHI, 32'h0, ALL);
        bus_write(A_MLO, 32'hFFFF_FFFE, ALL);
        repeat (2) @(negedge clock);
        bus_read(A_MLO, 32'h0);
        bus_read(A_MHI, 32'h1);

        // 64-bit wrap to zero
        bus_write(A_MHI, 32'hFFFF_FFFF, ALL);
        bus_write(A_MLO, 32'hFFFF_FFFF, ALL);
        bus_read(A_MLO, 32'hFFFF_FFFF);
        chk("irq_at_all_ones", irq, 1);
        bus_read(A_MLO, 32'h0);
        chk("irq_after_wrap", irq, 0);
        bus_read(A_MHI, 32'h0);

        // Halt freezes counting, then enable cleared
        halt = 1'b1;
        bus_write(A_MHI, 32'h1234_5678, ALL);
        bus_write(A_MLO, 32'h9ABC_DEF0, ALL);
        repeat (50) @(negedge clock);
        bus_read(A_MLO, 32'h9ABC_DEF0);
        bus_read(A_MHI, 32'h1234_5678);
        bus_write(A_CTRL, 32'h0, ALL);
        halt = 1'b0;
        repeat (10) @(negedge clock);
        bus_read(A_MLO, 32'h9ABC_DEF0);

        // Register access table with counting stopped
`ifdef MTIMER_PRESCALER_EN
        exp_ps = 32'h0000_0005;
`else
        exp_ps = 32'h0;
`endif
        tbl.push_back('{1'b1, A_MLO,  32'h0000_00AB, 4'b0001, 32'h0});
        tbl.push_back('{1'b0, A_MLO,  32'h0,         4'b0000, 32'h9ABC_DEAB});
        tbl.push_back('{1'b0, A_MHI,  32'h0,         4'b0000, 32'h1234_5678});
        tbl.push_back('{1'b1, A_MHI,  32'hFFFF_0000, 4'b1100, 32'h0});
        tbl.push_back('{1'b0, A_MLO,  32'h0,         4'b0000, 32'h9ABC_DEAB});
        tbl.push_back('{1'b0, A_MHI,  32'h0,         4'b0000, 32'hFFFF_5678});
        tbl.push_back('{1'b1, A_CLO,  32'h1122_3344, 4'b1111, 32'h0});
        tbl.push_back('{1'b0, A_CLO,  32'h0,         4'b0000, 32'h1122_3344});
        tbl.push_back('{1'b1, A_CHI,  32'h5566_7788, 4'b0110, 32'h0});
        tbl.push_back('{1'b0, A_CHI,  32'h0,         4'b0000, 32'hFF66_77FF});
        tbl.push_back('{1'b1, A_CTRL, 32'h0000_0003, 4'b0000, 32'h0});
        tbl.push_back('{1'b0, A_CTRL, 32'h0,         4'b0000, 32'h0000_0002});
        tbl.push_back('{1'b1, A_NONE, 32'hFFFF_FFFF, 4'b1111, 32'h0});
        tbl.push_back('{1'b0, A_NONE, 32'h0,         4'b0000, 32'h0});
        tbl.push_back('{1'b0, A_FREQ, 32'h0,         4'b0000, FREQ_HZ});
        tbl.push_back('{1'b1, A_FREQ, 32'h0,         4'b1111, 32'h0});
        tbl.push_back('{1'b0, A_FREQ, 32'h0,         4'b0000, FREQ_HZ});
        tbl.push_back('{1'b1, A_PS,   32'hABCD_0005, 4'b1111, 32'h0});
        tbl.push_back('{1'b0, A_PS,   32'h0,         4'b0000, exp_ps});
        tbl.push_back('{1'b1, A_PS,   32'h0,         4'b1111, 32'h0});
        tbl.push_back('{1'b1, A_CHI,  32'hFFFF_FFFF, 4'b1111, 32'h0});
        tbl.push_back('{1'b1, A_CLO,  32'hFFFF_FFFF, 4'b1111, 32'h0});
        tbl.push_back('{1'b0, A_CTRL, 32'h0,         4'b0000, 32'h0});
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].wr)
                bus_write(tbl[i].addr, tbl[i].data, tbl[i].strb);
            else
                bus_read(tbl[i].addr, tbl[i].exp);
        end

        // Simultaneous read and write: read returns the pre-write value
        bus_rw(A_CLO, 32'hCAFE_F00D, 32'hFFFF_FFFF);
        bus_read(A_CLO, 32'hCAFE_F00D);
        bus_write(A_CLO, 32'hFFFF_FFFF, ALL);

`ifdef MTIMER_PRESCALER_EN
        // Prescale of 3: one tick per four cycles, restart on rewrite
        bus_write(A_MHI, 32'h0, ALL);
        bus_write(A_MLO, 32'h0, ALL);
        bus_write(A_PS, 32'd3, ALL);
        bus_write(A_CTRL, 32'h1, ALL);
        repeat (11) @(negedge clock);
        bus_read(A_MLO, 32'd2);
        bus_read(A_MLO, 32'd3);
        bus_write(A_PS, 32'd3, ALL);
        repeat (3) @(negedge clock);
        bus_read(A_MLO, 32'd3);
        bus_read(A_MLO, 32'd4);
        bus_write(A_CTRL, 32'h0, ALL);
`endif

        // Reset in the middle of bus traffic
        bus_write(A_PS, 32'd7, ALL);
        bus_write(A_CHI, 32'h0, ALL);
        bus_write(A_CLO, 32'h0, ALL);
        @(negedge clock);
        chk("irq_before_reset", irq, 1);
        bus_read(A_FREQ, FREQ_HZ);
        sb.push_back('{A_CTRL, 32'h0});
        address      = A_CTRL;
        read_request = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        chk("reset_drops_read_response", read_response, 0);
        chk("reset_clears_read_data", read_data, 0);
        chk("reset_clears_irq", irq, 0);
        @(negedge clock);
        chk("pending_read_dropped", read_response, 0);
        read_request = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        bus_read(A_MLO, 32'h0);
        bus_read(A_MHI, 32'h0);
        bus_read(A_CHI, 32'hFFFF_FFFF);
        bus_read(A_CLO, 32'hFFFF_FFFF);
        bus_read(A_PS, 32'h0);
        bus_read(A_CTRL, 32'h1);
        chk("irq_after_reset", irq, 0);

        repeat (2) @(negedge clock);
        chk("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mtimer_controller.md
# mtimer_controller

Memory-mapped RISC-V machine timer for the RVX microcontroller: a free-running 64-bit `mtime` counter, a 64-bit `mtimecmp` compare register and a level machine-timer interrupt. Sits on the RVX system bus beside UART/GPIO/SPI and drives the core's timer interrupt input. Counting freezes while the core is halted.

## Interface

- `CLOCK_FREQUENCY`, 12000000: system clock in Hz. Informational only; exported as a read-only register.

- `clock`  in  1  system clock
- `reset_n`  in  1  asynchronous, active-low reset
- `halt`  in  1  core halt; freezes counting while high
- `address`  in  5  byte offset within the block (bits [1:0] ignored)
- `read_request`  in  1  single-cycle read strobe
- `read_data`  out  32  read data, valid with `read_response`
- `read_response`  out  1  read completion pulse
- `write_request`  in  1  single-cycle write strobe
- `write_data`  in  32  write data
- `write_strobe`  in  4  byte enables
- `write_response`  out  1  write completion pulse
- `irq`  out  1  machine timer interrupt, level

## Operation

- Register map:
  - 0x00 CTRL: bit0 `enable` (rw); bit1 `pending` (ro, mirrors `irq`).
  - 0x04 MTIME_LO, 0x08 MTIME_HI: rw.
  - 0x0C MTIMECMP_LO, 0x10 MTIMECMP_HI: rw.
  - 0x14 PRESCALE: rw when compiled in (see Configuration).
  - 0x18 FREQ: ro `CLOCK_FREQUENCY`.
  - Others: read 0, writes ignored, still acknowledged.
- Reset values: `mtime`=0, `mtimecmp`=0xFFFF_FFFF_FFFF_FFFF, `enable`=1, PRESCALE=0, prescale counter=0, hi shadow=0, `irq`=0, `read_response`=0, `write_response`=0, `read_data`=0.
- Tick: when `enable`=1 and `halt`=0, the prescale counter increments each cycle. When it equals PRESCALE it returns to 0 and `mtime` increments by 1. Effective period is PRESCALE+1 cycles.
- `mtime` wraps from 0xFFFF_FFFF_FFFF_FFFF to 0 with no flag.
- `enable`=0 or `halt`=1 holds both `mtime` and the prescale counter.
- Coherent read:
  - Reading MTIME_LO latches the current `mtime[63:32]` into a hi shadow.
  - Reading MTIME_HI returns the shadow.
  - Software therefore reads LO then HI.
- Writes honour `write_strobe` per byte. Unstrobed bytes are unchanged.
- Write to MTIME_LO/HI in a tick cycle: the written half takes the written bytes, the unwritten half holds, and that cycle's increment is dropped. No carry is applied.
- Write to PRESCALE clears the prescale counter.
- `irq` is registered from (`mtime` >= `mtimecmp`), 64-bit unsigned, re-evaluated every cycle. It deasserts one cycle after software raises `mtimecmp` above `mtime`.

## Timing

- Read: request in cycle N → `read_data` and `read_response` in cycle N+1. `read_response` is one cycle wide.
- Write: request in cycle N → register updated and `write_response` in cycle N+1.
- Read and write requests in the same cycle: both are serviced. The read returns the pre-write value.
- Back-to-back requests are accepted every cycle. No stall.
- `irq` latency: `mtime` (or `mtimecmp`) register update in cycle N → `irq` reflects the comparison in cycle N+1.
- Asserting `reset_n` low mid-transaction drops any pending response. All outputs go to their reset values immediately.

## Configuration

- `MTIMER_PRESCALER_EN` defined:
  - PRESCALE register and prescale counter are present, 16 bits wide.
  - 0x14 is rw.
- `MTIMER_PRESCALER_EN` undefined:
  - No prescaler. `mtime` increments every enabled, non-halted cycle.
  - 0x14 reads 0, writes are ignored but acknowledged.

## Structure

- Package `mtimer_pkg`: register offset constants (`MTIMER_CTRL`, `MTIMER_MTIME_LO`, …, `MTIMER_FREQ`), CTRL bit indices, reset value of `mtimecmp`.
- One natural sub-module: `mtimer_prescaler`. It holds the counter, PRESCALE compare and `tick` output, and exists only under `MTIMER_PRESCALER_EN`.
- The top holds the bus decode, the 64-bit registers, the shadow and the comparator.

## Test plan

- Reset, PRESCALE=0, no writes: after 10 cycles, MTIME_LO reads 10 (±1 for read latency); `irq`=0.
- Write MTIMECMP_HI=0, MTIMECMP_LO=20 → `irq` rises exactly one cycle after `mtime` reaches 20. Then write MTIMECMP_LO=0xFFFF_FFFF → `irq` falls one cycle after the write.
- Write MTIME_HI=0, MTIME_LO=0xFFFF_FFFE; read LO after the wrap → HI returns 1, LO small. Then write MTIME=0xFFFF_FFFF_FFFF_FFFF → next tick gives `mtime`=0.
- With `MTIMER_PRESCALER_EN`, PRESCALE=3: `mtime` advances once per 4 cycles. Rewrite PRESCALE mid-count → counter restarts from 0.
- Hold `halt`=1 for 50 cycles, then clear CTRL.enable → `mtime` frozen throughout; write `write_strobe`=4'b0001, `write_data`=0xAB to MTIME_LO → only byte 0 changes.
- Assert `reset_n` low during an outstanding read → no `read_response`; all registers return to reset values; `irq`=0.
